// File: rtl/mem_bridge_pkg.sv
// Shared types and sizing constants for the CPU-to-memory bridge.
package mem_bridge_pkg;
    localparam int STATE_W = 2;
    localparam int LAT_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        RD_WAIT = 2'd2,
        DONE    = 2'd3
    } bridgeState;
endpackage

// File: rtl/mem_bridge_wbuf_entry.sv
// One-entry posted write buffer: holds a store until drained and flags
// read requests that target the same word.
module wbuf_entry
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] loadAddr,
    input  logic [DATA_W-1:0] loadData,
    input  logic [ADDR_W-3:0] lookupWord,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              hit
);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= loadAddr;
            data  <= loadData;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    // Byte offset is ignored: any access inside the buffered word hits.
    assign hit = valid && (addr[ADDR_W-1:2] == lookupWord);
endmodule

// File: rtl/mem_bridge.sv
// Converts CPU memory accesses into a registered memory strobe interface,
// with a posted store buffer, read forwarding and access counters.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wbuf_valid,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);
    bridgeState        state;
    logic [LAT_W-1:0]  latCnt;
    logic              bufLoad;
    logic              bufClear;
    logic              bufHit;
    logic [ADDR_W-1:0] bufAddr;
    logic [DATA_W-1:0] bufData;

    assign bufLoad  = (state == IDLE) && cpu_req && cpu_wr;
    // The drain strobe is on the memory bus during the second DRAIN cycle.
    assign bufClear = (state == DRAIN) && mem_en;

    wbuf_entry #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) wbuf (
        .clock      (clock),
        .reset      (reset),
        .load       (bufLoad),
        .clear      (bufClear),
        .loadAddr   (cpu_addr),
        .loadData   (cpu_wdata),
        .lookupWord (cpu_addr[ADDR_W-1:2]),
        .valid      (wbuf_valid),
        .addr       (bufAddr),
        .data       (bufData),
        .hit        (bufHit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            latCnt    <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req && cpu_wr) begin
                        cpu_ready <= 1'b1;
                        wr_count  <= wr_count + CNT_W'(1);
                        state     <= DRAIN;
                    end else if (cpu_req) begin
                        mem_en   <= 1'b1;
                        mem_wr   <= 1'b0;
                        mem_addr <= cpu_addr;
                        latCnt   <= LAT_W'(READ_LAT);
                        state    <= RD_WAIT;
                    end
                end
                DRAIN: begin
                    if (!mem_en) begin
                        // Store-completion cycle: requests are ignored here.
                        cpu_ready <= 1'b0;
                        mem_en    <= 1'b1;
                        mem_wr    <= 1'b1;
                        mem_addr  <= bufAddr;
                        mem_wdata <= bufData;
                    end else begin
                        mem_en <= 1'b0;
                        mem_wr <= 1'b0;
                        state  <= IDLE;
                        if (cpu_req && !cpu_wr && bufHit) begin
                            cpu_rdata <= bufData;
                            cpu_ready <= 1'b1;
                            rd_count  <= rd_count + CNT_W'(1);
                            state     <= DONE;
                        end
                    end
                end
                RD_WAIT: begin
                    // First cycle only retires the strobe so that the ready
                    // edge lands READ_LAT+2 edges after acceptance.
                    if (mem_en) begin
                        mem_en <= 1'b0;
                    end else if (latCnt == '0) begin
                        cpu_rdata <= mem_rdata;
                        cpu_ready <= 1'b1;
                        rd_count  <= rd_count + CNT_W'(1);
                        state     <= DONE;
                    end else begin
                        latCnt <= latCnt - LAT_W'(1);
                    end
                end
                DONE: begin
                    cpu_ready <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: instance A (READ_LAT=1) and instance B
// (READ_LAT=4, 4-bit counters) share one CPU stimulus port, selected by sel.
module tb_mem_bridge;
    localparam logic [31:0] POISON = 32'hBAD0BAD0;

    logic        clock;
    logic        reset;
    logic        sel;
    logic        cpuReq;
    logic        cpuWr;
    logic [31:0] cpuAddr;
    logic [31:0] cpuWdata;
    logic [31:0] memRdata;

    logic        reqA, reqB;
    logic [31:0] rdataA, rdataB, memAddrA, memAddrB, memWdataA, memWdataB;
    logic        readyA, readyB, memEnA, memEnB, memWrA, memWrB, wbufA, wbufB;
    logic [31:0] rdCountA, wrCountA;
    logic [3:0]  rdCountB, wrCountB;

    logic        readyS, memEnS, memWrS, wbufS;
    logic [31:0] rdataS, memAddrS, memWdataS, rdCountS, wrCountS;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rdEns = 0;
    int wrEns = 0;
    int lastRdEnCyc = -1;
    int lastWrEnCyc = -1;
    int badWr = 0;
    logic [31:0] pipe [5];

    assign reqA = cpuReq & ~sel;
    assign reqB = cpuReq & sel;

    assign readyS    = sel ? readyB : readyA;
    assign memEnS    = sel ? memEnB : memEnA;
    assign memWrS    = sel ? memWrB : memWrA;
    assign wbufS     = sel ? wbufB : wbufA;
    assign rdataS    = sel ? rdataB : rdataA;
    assign memAddrS  = sel ? memAddrB : memAddrA;
    assign memWdataS = sel ? memWdataB : memWdataA;
    assign rdCountS  = sel ? {28'd0, rdCountB} : rdCountA;
    assign wrCountS  = sel ? {28'd0, wrCountB} : wrCountA;
    assign memRdata  = sel ? pipe[4] : pipe[1];

    mem_bridge #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1), .CNT_W(32)) dutA (
        .clock(clock), .reset(reset), .cpu_req(reqA), .cpu_wr(cpuWr),
        .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata), .cpu_rdata(rdataA),
        .cpu_ready(readyA), .mem_en(memEnA), .mem_wr(memWrA),
        .mem_addr(memAddrA), .mem_wdata(memWdataA), .mem_rdata(memRdata),
        .wbuf_valid(wbufA), .rd_count(rdCountA), .wr_count(wrCountA)
    );

    mem_bridge #(.ADDR_W(32), .DATA_W(32), .READ_LAT(4), .CNT_W(4)) dutB (
        .clock(clock), .reset(reset), .cpu_req(reqB), .cpu_wr(cpuWr),
        .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata), .cpu_rdata(rdataB),
        .cpu_ready(readyB), .mem_en(memEnB), .mem_wr(memWrB),
        .mem_addr(memAddrB), .mem_wdata(memWdataB), .mem_rdata(memRdata),
        .wbuf_valid(wbufB), .rd_count(rdCountB), .wr_count(wrCountB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] romWord(input logic [31:0] a);
        case (a[31:2])
            30'h10:  return 32'hDEADBEEF;
            30'h80:  return 32'hCAFEF00D;
            30'h40:  return 32'h99999999;
            default: return {a[31:2], 2'b00} ^ 32'hA5A50000;
        endcase
    endfunction

    // Memory model: read data appears READ_LAT edges after the strobe is sampled.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        pipe[0] <= (memEnS && !memWrS) ? romWord(memAddrS) : POISON;
        for (int k = 1; k < 5; k++) pipe[k] <= pipe[k-1];
        if (memWrS && !memEnS) badWr <= badWr + 1;
        if (memEnS) begin
            if (memWrS) begin
                wrEns <= wrEns + 1;
                lastWrEnCyc <= cyc;
            end else begin
                rdEns <= rdEns + 1;
                lastRdEnCyc <= cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vector %0d %s observed %0h expected %0h", vectors, tag, obs, exp);
    endtask

    task automatic doAccess(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output int startCyc, output int readyCyc, output logic [31:0] rdata);
        logic got;
        int n;
        cpuReq = 1'b1;
        cpuWr = wr;
        cpuAddr = addr;
        cpuWdata = wdata;
        startCyc = cyc;
        got = 1'b0;
        n = 0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (readyS) got = 1'b1;
        end
        readyCyc = cyc;
        rdata = rdataS;
        check("handshake_seen", {63'd0, got}, 64'd1);
    endtask

    initial begin
        int s, r, a, e0;
        logic [31:0] d;

        reset = 1'b0;
        sel = 1'b0;
        cpuReq = 1'b0;
        cpuWr = 1'b0;
        cpuAddr = '0;
        cpuWdata = '0;
        #3;
        check("reset_ready", {63'd0, readyS}, 64'd0);
        check("reset_mem_en", {63'd0, memEnS}, 64'd0);
        check("reset_rd_count", {32'd0, rdCountS}, 64'd0);
        tick();
        tick();
        #2 reset = 1'b1;
        tick();

        // Read from memory, READ_LAT=1
        e0 = rdEns;
        doAccess(1'b0, 32'h40, 32'h0, s, r, d);
        check("rd_latency", 64'(r - (s + 1)), 64'd3);
        check("rd_data", {32'd0, d}, 64'hDEADBEEF);
        check("rd_strobe_cycle", 64'(lastRdEnCyc), 64'(s + 1));
        cpuReq = 1'b0;
        tick();
        check("rd_ready_pulse", {63'd0, readyS}, 64'd0);
        check("rd_count_1", {32'd0, rdCountS}, 64'd1);
        check("rd_single_strobe", 64'(rdEns - e0), 64'd1);

        // Posted write and drain
        doAccess(1'b1, 32'h80, 32'h11223344, s, r, d);
        check("wr_latency", 64'(r - s), 64'd1);
        check("wr_wbuf_set", {63'd0, wbufS}, 64'd1);
        check("wr_count_1", {32'd0, wrCountS}, 64'd1);
        check("wr_no_strobe_yet", {63'd0, memEnS}, 64'd0);
        cpuReq = 1'b0;
        tick();
        check("drain_ready_low", {63'd0, readyS}, 64'd0);
        check("drain_mem_en", {63'd0, memEnS}, 64'd1);
        check("drain_mem_wr", {63'd0, memWrS}, 64'd1);
        check("drain_mem_addr", {32'd0, memAddrS}, 64'h80);
        check("drain_mem_wdata", {32'd0, memWdataS}, 64'h11223344);
        tick();
        check("drain_done_en", {63'd0, memEnS}, 64'd0);
        check("drain_wbuf_clear", {63'd0, wbufS}, 64'd0);
        check("wr_keeps_rdata", {32'd0, rdataS}, 64'hDEADBEEF);

        // Store then load of the same word: forwarded
        e0 = rdEns;
        doAccess(1'b1, 32'h100, 32'h55, s, a, d);
        doAccess(1'b0, 32'h102, 32'h0, s, r, d);
        check("fwd_latency", 64'(r - a), 64'd2);
        check("fwd_data", {32'd0, d}, 64'h55);
        cpuReq = 1'b0;
        tick();
        tick();
        check("fwd_no_mem_read", 64'(rdEns - e0), 64'd0);
        check("fwd_rd_count", {32'd0, rdCountS}, 64'd2);
        check("fwd_wbuf_clear", {63'd0, wbufS}, 64'd0);

        // Store then load of another word: load waits for the drain
        doAccess(1'b1, 32'h100, 32'h77, s, a, d);
        doAccess(1'b0, 32'h202, 32'h0, s, r, d);
        check("miss_drain_cycle", 64'(lastWrEnCyc), 64'(a + 1));
        check("miss_rd_strobe", 64'(lastRdEnCyc), 64'(a + 3));
        check("miss_latency", 64'(r - lastRdEnCyc), 64'd3);
        check("miss_data", {32'd0, d}, 64'hCAFEF00D);
        check("addr_lsb_pass", {32'd0, memAddrS}, 64'h202);
        cpuReq = 1'b0;
        tick();
        check("miss_rd_count", {32'd0, rdCountS}, 64'd3);
        check("miss_wr_count", {32'd0, wrCountS}, 64'd3);

        // Asynchronous reset in the middle of a READ_LAT=4 read
        sel = 1'b1;
        tick();
        cpuReq = 1'b1;
        cpuWr = 1'b0;
        cpuAddr = 32'h40;
        tick();
        check("b_rd_strobe", {63'd0, memEnS}, 64'd1);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        check("async_ready", {63'd0, readyS}, 64'd0);
        check("async_mem_addr", {32'd0, memAddrS}, 64'd0);
        check("async_a_rd_count", {32'd0, rdCountA}, 64'd0);
        check("async_a_wr_count", {32'd0, wrCountA}, 64'd0);
        check("async_a_rdata", {32'd0, rdataA}, 64'd0);
        cpuReq = 1'b0;
        tick();
        tick();
        check("reset_hold_ready", {63'd0, readyS}, 64'd0);
        #2 reset = 1'b1;
        tick();
        doAccess(1'b0, 32'h40, 32'h0, s, r, d);
        check("b_rd_latency", 64'(r - (s + 1)), 64'd6);
        check("b_rd_data", {32'd0, d}, 64'hDEADBEEF);
        cpuReq = 1'b0;
        tick();
        check("b_rd_count", {32'd0, rdCountS}, 64'd1);

        // Counter wrap with 4-bit counters
        for (int i = 0; i < 15; i++) begin
            doAccess(1'b1, 32'h300 + 32'(4 * i), 32'(i), s, r, d);
        end
        cpuReq = 1'b0;
        tick();
        tick();
        tick();
        check("wr_count_max", {32'd0, wrCountS}, 64'd15);
        doAccess(1'b1, 32'h400, 32'hAB, s, r, d);
        check("wr_count_wrap", {32'd0, wrCountS}, 64'd0);
        cpuReq = 1'b0;
        tick();
        tick();
        tick();
        check("wrap_wbuf_clear", {63'd0, wbufS}, 64'd0);
        check("mem_wr_only_with_en", 64'(badWr), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
